// File: rtl/irq_controller.sv
// Interrupt controller: captures per-source raise/ack requests, forwards one
// prioritised request to the processor and exposes a small register block on the shared bus.
module irq_controller #(
  parameter int unsigned NUM_SRC   = 4,
  parameter logic [7:0]  BASE_ADDR = 8'hE0
) (
  input  logic               CLK,
  input  logic               RESET,
  inout  wire  [7:0]         BUS_DATA,
  input  logic [7:0]         BUS_ADDR,
  input  logic               BUS_WE,
  input  logic [NUM_SRC-1:0] SRC_RAISE,
  output logic [NUM_SRC-1:0] SRC_ACK,
  output logic               INT_RAISE,
  input  logic               INT_ACK
);

  localparam int unsigned IDW = 3;

  typedef enum logic [1:0] {IDLE, RAISED, SERVE} state_t;

  state_t             state;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] src_ack;
  logic [NUM_SRC-1:0] capture;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] clr_w1c;
  logic [NUM_SRC-1:0] serve_clr;
  logic [NUM_SRC-1:0] sel_onehot;
  logic [1:0]         ctrl;
  logic               cur_valid;
  logic               cur_spur;
  logic [IDW-1:0]     cur_src;
  logic [IDW-1:0]     sel;
  logic [IDW-1:0]     last_served;
  logic [IDW-1:0]     winner;
  logic               winner_found;
  logic               int_raise;
  logic               spurious;
  logic [7:0]         wdata;
  logic [7:0]         offset;
  logic               hit;
  logic               wr;
  logic               eoi;
  logic [7:0]         rd_mux;
  logic [7:0]         rd_data;
  logic               rd_valid;
  logic               unused_wdata;
  int unsigned        rr_start;
  int unsigned        idx;

  // Bus decode; offset wraps so the block may sit anywhere in the map
  assign wdata        = BUS_DATA;
  assign unused_wdata = ^wdata;
  assign offset       = BUS_ADDR - BASE_ADDR;
  assign hit          = offset < 8'd5;
  assign wr           = hit && BUS_WE;
  assign eoi          = wr && (offset == 8'd2);

  assign BUS_DATA  = rd_valid ? rd_data : 8'hzz;
  assign SRC_ACK   = src_ack;
  assign INT_RAISE = int_raise;

  // A source still high during its ack cycle is not captured again
  assign capture    = SRC_RAISE & ~src_ack;
  assign eligible   = (ctrl[0] && !cur_valid) ? (pending & mask) : '0;
  assign clr_w1c    = (wr && offset == 8'd3) ? wdata[NUM_SRC-1:0] : '0;
  assign sel_onehot = NUM_SRC'(1) << sel;
  assign serve_clr  = (state == SERVE) ? sel_onehot : '0;
  assign spurious   = ~|(pending & sel_onehot);

  // Winner search: ascending index, rotated past last-served in round-robin
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    idx          = 0;
    rr_start     = (32'(last_served) + 1) % NUM_SRC;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = ctrl[1] ? (rr_start + k) % NUM_SRC : k;
      if (!winner_found && eligible[idx]) begin
        winner       = IDW'(idx);
        winner_found = 1'b1;
      end
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (offset)
      8'd0:    rd_mux = 8'(pending);
      8'd1:    rd_mux = 8'(mask);
      8'd2:    rd_mux = {cur_valid, cur_spur, 3'b000, cur_src};
      8'd4:    rd_mux = {6'b000000, ctrl};
      default: rd_mux = 8'h00;
    endcase
  end

  // Register file, source capture and registered read return
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pending  <= '0;
      mask     <= '1;
      ctrl     <= 2'b01;
      src_ack  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      src_ack  <= capture;
      pending  <= (pending & ~clr_w1c & ~serve_clr) | capture;
      if (wr && offset == 8'd1) mask <= wdata[NUM_SRC-1:0];
      if (wr && offset == 8'd4) ctrl <= wdata[1:0];
      rd_valid <= hit && !BUS_WE;
      rd_data  <= (hit && !BUS_WE) ? rd_mux : 8'h00;
    end
  end

  // Request handshake and in-service tracking
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      int_raise   <= 1'b0;
      sel         <= '0;
      cur_valid   <= 1'b0;
      cur_spur    <= 1'b0;
      cur_src     <= '0;
      last_served <= IDW'(NUM_SRC - 1);
    end else begin
      if (eoi) begin
        cur_valid <= 1'b0;
        cur_spur  <= 1'b0;
        cur_src   <= '0;
      end
      case (state)
        IDLE: begin
          if (winner_found) begin
            sel       <= winner;
            int_raise <= 1'b1;
            state     <= RAISED;
          end
        end
        RAISED: begin
          if (INT_ACK) begin
            int_raise <= 1'b0;
            state     <= SERVE;
          end
        end
        SERVE: begin
          cur_valid   <= 1'b1;
          cur_spur    <= spurious;
          cur_src     <= sel;
          last_served <= sel;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
